rf_bypass_sb: RTL

- Parametrised successor to the 8x16b bypassed register file: configurable data width, depth and read-port count.
- Write-to-read bypass is qualified by the write enable.
- Optional hardwired zero register.
- Per-register pending-write scoreboard, so the decode stage can detect RAW hazards that bypass cannot resolve.
- Sits between decode (reads, issue) and writeback (write) in the pipelined core.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_bypass_sb_if.sv | 32 +++
 rtl/rf_scoreboard.sv | 65 ++++++
 rtl/rf_bypass_sb.sv | 67 ++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the bypassed register file slice.
// Default geometry, select type and flat-bus slice helper.
package rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_SEL_W    = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_SEL_W-1:0] rsel_t;

  function automatic int slice_lo(
    input int idx,
    input int w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_bypass_sb_if.sv
// Decode/writeback bundle for the bypassed register file.
// master = pipeline side, slave = register file side.
interface rf_bypass_sb_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic [NUM_RD*SEL_W-1:0]  rd_sel;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [SEL_W-1:0]         wr_sel;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [SEL_W-1:0]         issue_sel;
  logic                     err;

  modport master (
    output rd_sel, wr_en, wr_sel, wr_data,
    output issue_en, issue_sel,
    input  rd_data, rd_busy, err
  );

  modport slave (
    input  rd_sel, wr_en, wr_sel, wr_data,
    input  issue_en, issue_sel,
    output rd_data, rd_busy, err
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy bits, sticky protocol error,
// and per-port busy qualified by the same-cycle writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b0,
  localparam int SEL_W   = $clog2(NUM_REGS)
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*SEL_W-1:0] rd_sel_i,
  input  logic                    wr_en_i,
  input  logic [SEL_W-1:0]        wr_sel_i,
  input  logic                    issue_en_i,
  input  logic [SEL_W-1:0]        issue_sel_i,
  output logic [NUM_RD-1:0]       rd_busy_o,
  output logic                    err_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;
  logic                waw, orphan, wr_live;

  assign wr_live = wr_en_i && !(ZERO_REG && wr_sel_i == '0);

  always_comb begin
    busy_d = busy_q;
    // issue after clear: a new producer outranks the retiring one
    if (wr_en_i)    busy_d[wr_sel_i]    = 1'b0;
    if (issue_en_i) busy_d[issue_sel_i] = 1'b1;
    if (ZERO_REG)   busy_d[0]           = 1'b0;
  end

  always_comb begin
    waw    = issue_en_i && busy_q[issue_sel_i]
             && !(wr_en_i && wr_sel_i == issue_sel_i);
    orphan = wr_live && !busy_q[wr_sel_i];
    err_d  = err_q || waw || orphan;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [SEL_W-1:0] s;
      s = rd_sel_i[slice_lo(i, SEL_W) +: SEL_W];
      rd_busy_o[i] = busy_q[s]
                     && !(wr_en_i && wr_sel_i == s);
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/rf_bypass_sb.sv
// Parametrised register file with qualified write-to-read bypass,
// optional zero register and a pending-write scoreboard.
module rf_bypass_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b0
)(
  input  logic         clk,
  input  logic         rst,
  rf_bypass_sb_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_do;

  assign wr_do = bus.wr_en
                 && !(ZERO_REG && bus.wr_sel == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= '0;
    end else if (wr_do) begin
      regs_q[bus.wr_sel] <= bus.wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [SEL_W-1:0] s;
      logic [DATA_W-1:0] d;
      s = bus.rd_sel[slice_lo(i, SEL_W) +: SEL_W];
      d = regs_q[s];
      if (ZERO_REG && s == '0)
        d = '0;
      else if (bus.wr_en && bus.wr_sel == s)
        d = bus.wr_data;
      rd_data[slice_lo(i, DATA_W) +: DATA_W] = d;
    end
  end

  assign bus.rd_data = rd_data;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rd_sel_i    (bus.rd_sel),
    .wr_en_i     (bus.wr_en),
    .wr_sel_i    (bus.wr_sel),
    .issue_en_i  (bus.issue_en),
    .issue_sel_i (bus.issue_sel),
    .rd_busy_o   (bus.rd_busy),
    .err_o       (bus.err)
  );

endmodule
